multi_channel_fifo: RTL and testbench

Parametrised N-channel buffer. Each channel has its own write port and storage, plus full/almost-full status and a sticky overflow flag. All channels drain through one round-robin arbiter into a single registered valid/ready output stream that carries the data word and its source channel index. It sits between independent producers and a shared downstream consumer, as the next generation of the per-channel FIFO bank.

---
 rtl/multi_fifo_pkg.sv | 27 ++
 rtl/multi_channel_fifo_channel.sv | 66 ++++++
 rtl/multi_channel_fifo.sv | 87 ++++++++
 tb/tb_multi_channel_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_fifo_pkg.sv
// Shared widths and round-robin grant selection for the multi-channel FIFO.
package multi_fifo_pkg;

  localparam int MAX_CH = 32;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // First requester strictly after last, searching cyclically; returns last if none.
  function automatic int rr_next(input logic [MAX_CH-1:0] req, input int last, input int n);
    int idx;
    rr_next = last;
    for (int k = MAX_CH; k >= 1; k--) begin
      if (k <= n) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        if (req[idx]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/multi_channel_fifo_channel.sv
// One channel: circular storage, pointers, occupancy count, status flags, sticky overflow.
module fifo_channel
  import multi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = DEPTH - 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    pop,
  input  logic                    ovf_clr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    full,
  output logic                    almost_full,
  output logic                    empty,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop_ok;

  assign full        = (count == CNT_W'(DEPTH));
  assign almost_full = (int'(count) >= AFULL_LVL);
  assign empty       = (count == '0);
  assign level       = count;
  assign rd_data     = mem[rd_ptr];
  assign push        = wr_en && !full;
  assign pop_ok      = pop && !empty;

  // Storage carries no reset; only pointers and count define valid contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped write takes priority over a clear in the same cycle.
      if (wr_en && full)  overflow <= 1'b1;
      else if (ovf_clr)   overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_channel_fifo.sv
// N independent channel FIFOs drained by a round-robin arbiter into one registered valid/ready stream.
module multi_channel_fifo
  import multi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_CH     = 4,
  parameter int AFULL_LVL  = DEPTH - 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CH-1:0]                   wr_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]        din,
  output logic [NUM_CH-1:0]                   full,
  output logic [NUM_CH-1:0]                   almost_full,
  output logic [NUM_CH-1:0]                   empty,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0] level,
  output logic [NUM_CH-1:0]                   overflow,
  input  logic [NUM_CH-1:0]                   ovf_clr,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [DATA_WIDTH-1:0]               m_data,
  output logic [ch_w(NUM_CH)-1:0]             m_ch
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int CH_W  = ch_w(NUM_CH);

  logic [DATA_WIDTH-1:0] rd_data [NUM_CH];
  logic [NUM_CH-1:0]     pop;
  logic [MAX_CH-1:0]     req;
  logic [CH_W-1:0]       grant;
  logic [CH_W-1:0]       last_grant;
  logic                  load_ok;
  logic                  any_req;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fifo_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AFULL_LVL  (AFULL_LVL)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en[i]),
      .din         (din[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop         (pop[i]),
      .ovf_clr     (ovf_clr[i]),
      .rd_data     (rd_data[i]),
      .full        (full[i]),
      .almost_full (almost_full[i]),
      .empty       (empty[i]),
      .overflow    (overflow[i]),
      .level       (level[i*CNT_W +: CNT_W])
    );
  end

  // Arbitration uses the registered empty flags, so a word written this cycle is not yet eligible.
  always_comb begin
    req                = '0;
    req[NUM_CH-1:0]    = ~empty;
    any_req            = |(~empty);
    load_ok            = !m_valid || m_ready;
    grant              = CH_W'(rr_next(req, int'(last_grant), NUM_CH));
    pop                = '0;
    if (load_ok && any_req) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_ch       <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (load_ok) begin
      if (any_req) begin
        m_valid    <= 1'b1;
        m_data     <= rd_data[grant];
        m_ch       <= grant;
        last_grant <= grant;
      end else begin
        m_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_fifo.sv
// Scoreboard bench: queue-based reference model predicts output words and status; a negedge monitor compares.
module tb_multi_channel_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int NCH   = 4;
  localparam int AFULL = DEPTH - 2;
  localparam int CNT_W = 5;
  localparam int CH_W  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       wr_en = '0;
  logic [NCH*DW-1:0]    din = '0;
  logic [NCH-1:0]       full, almost_full, empty, overflow;
  logic [NCH*CNT_W-1:0] level;
  logic [NCH-1:0]       ovf_clr = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic [DW-1:0]        m_data;
  logic [CH_W-1:0]      m_ch;

  always #5 clk = ~clk;

  multi_channel_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .NUM_CH     (NCH),
    .AFULL_LVL  (AFULL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .din         (din),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_ch        (m_ch)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            ch;
  } word_t;

  logic [DW-1:0] q [NCH][$];
  word_t         expq[$];
  int            seen_ch[$];
  bit            mv = 1'b0;
  int            last = NCH - 1;
  logic [NCH-1:0] ovf_m = '0;
  int            pre_sz [NCH];
  int            g;
  word_t         w;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: channels are plain queues, output register is a single held word.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) q[c].delete();
      expq.delete();
      mv    = 1'b0;
      last  = NCH - 1;
      ovf_m = '0;
    end else begin
      for (int c = 0; c < NCH; c++) pre_sz[c] = q[c].size();
      if (!mv || m_ready) begin
        g = -1;
        for (int k = 1; k <= NCH; k++)
          if (g < 0 && pre_sz[(last + k) % NCH] > 0) g = (last + k) % NCH;
        if (g >= 0) begin
          w.d  = q[g].pop_front();
          w.ch = g;
          expq.push_back(w);
          last = g;
          mv   = 1'b1;
        end else begin
          mv = 1'b0;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (wr_en[c] && pre_sz[c] < DEPTH) q[c].push_back(din[c*DW +: DW]);
        if (wr_en[c] && pre_sz[c] == DEPTH) ovf_m[c] = 1'b1;
        else if (ovf_clr[c])                ovf_m[c] = 1'b0;
      end
    end
  end

  logic [NCH*CNT_W-1:0] lv_m;
  logic [NCH-1:0]       f_m, af_m, e_m;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        lv_m[c*CNT_W +: CNT_W] = CNT_W'(q[c].size());
        f_m[c]  = (q[c].size() == DEPTH);
        af_m[c] = (q[c].size() >= AFULL);
        e_m[c]  = (q[c].size() == 0);
      end
      chk("m_valid", 64'(m_valid), 64'(mv));
      chk("level", 64'(level), 64'(lv_m));
      chk("full", 64'(full), 64'(f_m));
      chk("almost_full", 64'(almost_full), 64'(af_m));
      chk("empty", 64'(empty), 64'(e_m));
      chk("overflow", 64'(overflow), 64'(ovf_m));
      if (m_valid) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: actual data=%0h ch=%0d required none at %0t", m_data, m_ch, $time);
        end else begin
          chk("m_data", 64'(m_data), 64'(expq[0].d));
          chk("m_ch", 64'(m_ch), 64'(expq[0].ch));
          if (m_ready) begin
            void'(expq.pop_front());
            seen_ch.push_back(int'(m_ch));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en   = '0;
    ovf_clr = '0;
    m_ready = 1'b0;
    rst_n   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    seen_ch.delete();
  endtask

  task automatic drain();
    int cyc;
    cyc     = 0;
    wr_en   = '0;
    ovf_clr = '0;
    m_ready = 1'b1;
    while ((m_valid || !(&empty)) && cyc < 200) begin
      step();
      cyc++;
    end
    chk("drain_in_time", 64'(cyc < 200), 64'(1));
    step();
    chk("drain_scoreboard_empty", 64'(expq.size()), 64'(0));
    chk("drain_m_valid", 64'(m_valid), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [DW-1:0]        hold_d;
  logic [CH_W-1:0]      hold_c;
  logic [NCH*CNT_W-1:0] hold_l;
  int                   rr_exp [3] = '{0, 1, 3};

  initial begin
    // Reset sanity and first-word latency
    do_reset();
    chk("rst_empty", 64'(empty), 64'(4'hF));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    din = '0;
    din[2*DW +: DW] = 8'hA5;
    wr_en = 4'b0100;
    step();
    wr_en = '0;
    step();
    chk("lat_valid", 64'(m_valid), 64'(1));
    chk("lat_data", 64'(m_data), 64'(8'hA5));
    chk("lat_ch", 64'(m_ch), 64'(2));
    drain();

    // Fill channel 0 to full with the output register occupied
    do_reset();
    din[1*DW +: DW] = 8'h11;
    wr_en = 4'b0010;
    step();
    wr_en = '0;
    step();
    for (int i = 0; i < 17; i++) begin
      din[0 +: DW] = DW'(8'h30 + i);
      wr_en = 4'b0001;
      step();
    end
    wr_en = '0;
    chk("fill_level0", 64'(level[0 +: CNT_W]), 64'(16));
    chk("fill_full0", 64'(full[0]), 64'(1));
    chk("fill_ovf0", 64'(overflow[0]), 64'(1));
    ovf_clr = 4'b0001;
    step();
    ovf_clr = '0;
    chk("ovf_clr0", 64'(overflow[0]), 64'(0));
    drain();

    // Round-robin over channels 0, 1, 3
    do_reset();
    m_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      din = 32'($urandom);
      wr_en = 4'b1011;
      step();
    end
    drain();
    chk("rr_count", 64'(seen_ch.size()), 64'(9));
    for (int i = 0; i < 9 && i < seen_ch.size(); i++)
      chk($sformatf("rr_seq_%0d", i), 64'(seen_ch[i]), 64'(rr_exp[i % 3]));

    // Backpressure hold, then full-rate streaming
    do_reset();
    for (int r = 0; r < 3; r++) begin
      din = 32'($urandom);
      wr_en = 4'b0101;
      step();
    end
    wr_en = '0;
    step();
    hold_d = m_data;
    hold_c = m_ch;
    hold_l = level;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_data", 64'(m_data), 64'(hold_d));
      chk("bp_ch", 64'(m_ch), 64'(hold_c));
      chk("bp_level", 64'(level), 64'(hold_l));
    end
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stream_valid", 64'(m_valid), 64'(1));
    end
    drain();

    // Write to a full channel in the same cycle it is popped
    do_reset();
    for (int i = 0; i < 17; i++) begin
      din[1*DW +: DW] = DW'(i);
      wr_en = 4'b0010;
      step();
    end
    wr_en = '0;
    chk("pf_full1", 64'(full[1]), 64'(1));
    m_ready = 1'b1;
    din[1*DW +: DW] = 8'hEE;
    wr_en = 4'b0010;
    step();
    wr_en = '0;
    m_ready = 1'b0;
    chk("pf_level1", 64'(level[1*CNT_W +: CNT_W]), 64'(15));
    chk("pf_ovf1", 64'(overflow[1]), 64'(1));
    drain();

    // 40 words through channel 3, wrapping the pointers
    do_reset();
    for (int i = 0; i < 40; i++) begin
      din[3*DW +: DW] = DW'(i);
      wr_en = 4'b1000;
      m_ready = (i % 4 != 3);
      step();
    end
    drain();
    chk("wrap_count", 64'(seen_ch.size()), 64'(40));

    // Reset asserted in the middle of a burst
    for (int i = 0; i < 10; i++) begin
      din = 32'($urandom);
      wr_en = 4'($urandom);
      m_ready = 1'b1;
      step();
    end
    wr_en = '0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(m_valid), 64'(0));
    chk("mid_rst_m_data", 64'(m_data), 64'(0));
    chk("mid_rst_m_ch", 64'(m_ch), 64'(0));
    chk("mid_rst_empty", 64'(empty), 64'(4'hF));
    chk("mid_rst_full", 64'(full), 64'(0));
    chk("mid_rst_afull", 64'(almost_full), 64'(0));
    chk("mid_rst_level", 64'(level), 64'(0));
    chk("mid_rst_ovf", 64'(overflow), 64'(0));
    step();
    rst_n = 1'b1;
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      din     = 32'($urandom);
      wr_en   = 4'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
